// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: one round per clock, on-the-fly key schedule.
// Vectors are MSB-first, so DES bit n of a W-bit vector sits at index W-n.
module des_round_engine #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_preout
);

  localparam int PC1 [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,
                              60,52,44,36,63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,
                              29,21,13, 5,28,20,12, 4};
  localparam int PC2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                              41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int EXP [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9,10,11,12,13,12,13,14,15,16,17,
                              16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32, 1};
  localparam int PERM [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                               2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Bit r set = single-bit rotate in round r+1 (otherwise two bits).
  localparam logic [15:0] ENC_ONE = 16'b1000_0001_0000_0011;
  localparam logic [15:0] DEC_ONE = 16'b1100_0000_1000_0001;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-EXP[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      s[31-4*b -: 4] = 4'(SBOX[b][{six[5], six[0], six[4:1]}]);
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-PERM[i]];
    return p;
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        mode_q, mode_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] preout_q, preout_d;

  logic        one_step;
  logic [27:0] c_enc, d_enc, c_dec, d_dec;
  logic [55:0] cd_load;
  logic [47:0] subkey;
  logic [31:0] r_new;

  always_comb begin
    one_step = mode_q ? DEC_ONE[rnd_q] : ENC_ONE[rnd_q];
    c_enc    = one_step ? {c_q[26:0], c_q[27]}  : {c_q[25:0], c_q[27:26]};
    d_enc    = one_step ? {d_q[26:0], d_q[27]}  : {d_q[25:0], d_q[27:26]};
    c_dec    = one_step ? {c_q[0], c_q[27:1]}   : {c_q[1:0], c_q[27:2]};
    d_dec    = one_step ? {d_q[0], d_q[27:1]}   : {d_q[1:0], d_q[27:2]};
    // Decrypt takes the key before rotating, so it walks K16 down to K1.
    subkey   = mode_q ? pc2({c_q, d_q}) : pc2({c_enc, d_enc});
    r_new    = l_q ^ feistel(r_q, subkey);
    cd_load  = pc1(in_key);
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    mode_d      = mode_q;
    rnd_d       = rnd_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    preout_d    = preout_q;
    case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        l_d     = in_block[63:32];
        r_d     = in_block[31:0];
        c_d     = cd_load[55:28];
        d_d     = cd_load[27:0];
        mode_d  = in_decrypt;
        rnd_d   = 4'd0;
        state_d = ROUND;
      end
      ROUND: begin
        l_d   = r_q;
        r_d   = r_new;
        c_d   = mode_q ? c_dec : c_enc;
        d_d   = mode_q ? d_dec : d_enc;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'(NUM_ROUNDS - 1)) begin
          preout_d    = {r_new, r_q};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mode_q      <= 1'b0;
      rnd_q       <= 4'd0;
      l_q         <= 32'h0;
      r_q         <= 32'h0;
      c_q         <= 28'h0;
      d_q         <= 28'h0;
      preout_q    <= 64'h0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
      rnd_q       <= rnd_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      preout_q    <= preout_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_preout = preout_q;

endmodule
